// File: rtl/pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// pll_lock_sequencer
//   Reset/lock sequencer for the audio-clock PLL. Pulses the PLL reset, waits
//   for a stable synchronized lock, then releases downstream audio reset.
//   Lock timeouts retry a bounded number of times before parking in FAULT.
//
// Ports
//   refclk      in   only clock, rising edge
//   rst         in   synchronous active-high reset
//   locked_in   in   PLL locked, asynchronous to refclk
//   relock_req  in   single-cycle restart request (RUN/LOST/FAULT only)
//   pll_rst     out  PLL reset
//   sys_rst     out  downstream audio reset, active high
//   ready       out  PLL stably locked, downstream running
//   fault       out  retries exhausted
//   retry_cnt   out  timeouts seen in the current sequence
//   lost_cnt    out  lock-loss events seen in RUN, saturating at 255
//
// Configuration macro
//   PLL_SEQ_AUTO_RELOCK_EN  defined: lock loss in RUN restarts the full
//                           sequence automatically (no LOST state).
//                           undefined: lock loss parks in LOST until
//                           relock_req.
// -----------------------------------------------------------------------------
module pll_lock_sequencer #(
   parameter int  RST_CYCLES   = 50,
   parameter int  LOCK_STABLE  = 1024,
   parameter int  LOCK_TIMEOUT = 50000,
   parameter int  MAX_RETRY    = 3,
   localparam int RETRY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               locked_in,
   input  logic               relock_req,
   output logic               pll_rst,
   output logic               sys_rst,
   output logic               ready,
   output logic               fault,
   output logic [RETRY_W-1:0] retry_cnt,
   output logic [7:0]         lost_cnt
);

   // One shared timer serves all timed states; it is sized for the largest limit.
   localparam int RST_W   = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)   : 1;
   localparam int STB_W   = (LOCK_STABLE  > 1) ? $clog2(LOCK_STABLE)  : 1;
   localparam int TMO_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
   localparam int CNT_W_A = (RST_W > STB_W) ? RST_W : STB_W;
   localparam int CNT_W   = (CNT_W_A > TMO_W) ? CNT_W_A : TMO_W;

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
`ifndef PLL_SEQ_AUTO_RELOCK_EN
      , S_LOST    = 3'd5
`endif
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_timer;
   logic [CNT_W-1:0]     w_timer_nxt;
   logic [RETRY_W-1:0]   r_retry_cnt;
   logic [RETRY_W-1:0]   w_retry_nxt;
   logic [7:0]           r_lost_cnt;
   logic [7:0]           w_lost_nxt;
   logic                 r_sync1;
   logic                 r_sync2;
   logic                 w_lock_s;
   logic                 r_pll_rst;
   logic                 r_sys_rst;
   logic                 r_ready;
   logic                 r_fault;
   logic                 w_pll_rst_nxt;
   logic                 w_sys_rst_nxt;
   logic                 w_ready_nxt;
   logic                 w_fault_nxt;

   assign w_lock_s  = r_sync2;
   assign pll_rst   = r_pll_rst;
   assign sys_rst   = r_sys_rst;
   assign ready     = r_ready;
   assign fault     = r_fault;
   assign retry_cnt = r_retry_cnt;
   assign lost_cnt  = r_lost_cnt;

   // Next-state, counter and registered-output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer + CNT_W'(1);
      w_retry_nxt = r_retry_cnt;
      w_lost_nxt  = r_lost_cnt;
      case (r_state)
         S_PLL_RST: begin
            if (r_timer == CNT_W'(RST_CYCLES - 1)) begin
               w_state_nxt = S_WAIT_LOCK;
               w_timer_nxt = '0;
            end else begin
               w_state_nxt = S_PLL_RST;
            end
         end
         S_WAIT_LOCK: begin
            // A lock seen on the expiry edge wins over the timeout.
            if (w_lock_s) begin
               w_state_nxt = S_STABLE;
               w_timer_nxt = '0;
            end else if (r_timer == CNT_W'(LOCK_TIMEOUT - 1)) begin
               w_timer_nxt = '0;
               if (r_retry_cnt == RETRY_W'(MAX_RETRY)) begin
                  w_state_nxt = S_FAULT;
               end else begin
                  w_state_nxt = S_PLL_RST;
                  w_retry_nxt = r_retry_cnt + RETRY_W'(1);
               end
            end else begin
               w_state_nxt = S_WAIT_LOCK;
            end
         end
         S_STABLE: begin
            if (!w_lock_s) begin
               w_state_nxt = S_WAIT_LOCK;
               w_timer_nxt = '0;
            end else if (r_timer == CNT_W'(LOCK_STABLE - 1)) begin
               w_state_nxt = S_RUN;
               w_timer_nxt = '0;
            end else begin
               w_state_nxt = S_STABLE;
            end
         end
         S_RUN: begin
            w_timer_nxt = '0;
            if (relock_req) begin
               w_state_nxt = S_PLL_RST;
               w_retry_nxt = '0;
            end else if (!w_lock_s) begin
               if (r_lost_cnt != 8'hFF) begin
                  w_lost_nxt = r_lost_cnt + 8'd1;
               end else begin
                  w_lost_nxt = r_lost_cnt;
               end
`ifdef PLL_SEQ_AUTO_RELOCK_EN
               w_state_nxt = S_PLL_RST;
               w_retry_nxt = '0;
`else
               w_state_nxt = S_LOST;
`endif
            end else begin
               w_state_nxt = S_RUN;
            end
         end
`ifndef PLL_SEQ_AUTO_RELOCK_EN
         S_LOST: begin
            w_timer_nxt = '0;
            if (relock_req) begin
               w_state_nxt = S_PLL_RST;
               w_retry_nxt = '0;
            end else begin
               w_state_nxt = S_LOST;
            end
         end
`endif
         S_FAULT: begin
            w_timer_nxt = '0;
            if (relock_req) begin
               w_state_nxt = S_PLL_RST;
               w_retry_nxt = '0;
            end else begin
               w_state_nxt = S_FAULT;
            end
         end
         default: begin
            w_state_nxt = S_PLL_RST;
            w_timer_nxt = '0;
            w_retry_nxt = '0;
         end
      endcase
      // Outputs are decoded from the next state so they move with the state.
      w_pll_rst_nxt = (w_state_nxt == S_PLL_RST) || (w_state_nxt == S_FAULT);
      w_sys_rst_nxt = (w_state_nxt != S_RUN);
      w_ready_nxt   = (w_state_nxt == S_RUN);
      w_fault_nxt   = (w_state_nxt == S_FAULT);
   end

   // State, counters, lock synchronizer and output registers.
   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state     <= S_PLL_RST;
         r_timer     <= '0;
         r_retry_cnt <= '0;
         r_lost_cnt  <= 8'd0;
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_pll_rst   <= 1'b1;
         r_sys_rst   <= 1'b1;
         r_ready     <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_timer     <= w_timer_nxt;
         r_retry_cnt <= w_retry_nxt;
         r_lost_cnt  <= w_lost_nxt;
         r_sync1     <= locked_in;
         r_sync2     <= r_sync1;
         r_pll_rst   <= w_pll_rst_nxt;
         r_sys_rst   <= w_sys_rst_nxt;
         r_ready     <= w_ready_nxt;
         r_fault     <= w_fault_nxt;
      end
   end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Directed stimulus pushes expected output words, tagged with the absolute
//   clock edge they apply to, into a scoreboard queue. A monitor samples the
//   DUT 2 time units after every rising edge and pops/compares every entry due
//   on that edge. Expected word = {pll_rst, sys_rst, ready, fault, retry, lost}.
// -----------------------------------------------------------------------------
module tb_pll_lock_sequencer;

   logic       refclk;
   logic       rst;
   logic       locked_in;
   logic       relock_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic [1:0] retry_cnt;
   logic [7:0] lost_cnt;

   typedef struct {
      int          cyc;
      string       name;
      logic [13:0] word;
   } exp_t;

   exp_t sb[$];
   int   edge_n   = 0;
   int   base     = 0;
   int   checks   = 0;
   int   failures = 0;
   int   t0       = 0;

   pll_lock_sequencer #(
      .RST_CYCLES   (4),
      .LOCK_STABLE  (8),
      .LOCK_TIMEOUT (32),
      .MAX_RETRY    (2)
   ) dut (
      .refclk     (refclk),
      .rst        (rst),
      .locked_in  (locked_in),
      .relock_req (relock_req),
      .pll_rst    (pll_rst),
      .sys_rst    (sys_rst),
      .ready      (ready),
      .fault      (fault),
      .retry_cnt  (retry_cnt),
      .lost_cnt   (lost_cnt)
   );

   initial begin
      refclk = 1'b0;
      forever #5 refclk = ~refclk;
   end

   always @(posedge refclk) edge_n = edge_n + 1;

   // flags = {pll_rst, sys_rst, ready, fault}
   function automatic logic [13:0] w(input logic [3:0] flags, input logic [1:0] rc, input logic [7:0] lc);
      return {flags, rc, lc};
   endfunction

   function automatic logic [7:0] sat8(input int n);
      return (n > 255) ? 8'd255 : 8'(n);
   endfunction

   task automatic push_abs(input int cyc, input string name, input logic [13:0] word);
      exp_t e;
      int   i;
      e.cyc  = cyc;
      e.name = name;
      e.word = word;
      i = sb.size();
      while (i > 0 && sb[i-1].cyc > cyc) i--;
      sb.insert(i, e);
   endtask

   task automatic chk(input int k, input string name, input logic [13:0] word);
      push_abs(base + k, name, word);
   endtask

   task automatic wait_edge(input int k);
      while (edge_n < base + k) @(negedge refclk);
   endtask

   task automatic do_reset(input logic lk);
      @(negedge refclk);
      rst        = 1'b1;
      relock_req = 1'b0;
      locked_in  = lk;
      push_abs(edge_n + 1, "rst_vals", w(4'b1100, 2'd0, 8'd0));
      @(negedge refclk);
      rst  = 1'b0;
      base = edge_n;
   endtask

   // Monitor: compare every scoreboard entry due on the edge just taken.
   initial begin
      exp_t        e;
      logic [13:0] obs;
      forever begin
         @(posedge refclk);
         #2;
         obs = {pll_rst, sys_rst, ready, fault, retry_cnt, lost_cnt};
         while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < edge_n) begin
               failures++;
               $display("FAIL %s late entry: due edge %0d, now edge %0d", e.name, e.cyc, edge_n);
            end else if (obs !== e.word) begin
               failures++;
               $display("FAIL %s edge=%0d got pll=%b sys=%b rdy=%b flt=%b retry=%0d lost=%0d want pll=%b sys=%b rdy=%b flt=%b retry=%0d lost=%0d",
                        e.name, edge_n, obs[13], obs[12], obs[11], obs[10], obs[9:8], obs[7:0],
                        e.word[13], e.word[12], e.word[11], e.word[10], e.word[9:8], e.word[7:0]);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at edge %0d", edge_n);
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      locked_in  = 1'b0;
      relock_req = 1'b0;

      // Clean lock: locked_in first sampled on edge 10.
      do_reset(1'b0);
      chk(3,  "clean_prst3",    w(4'b1100, 2'd0, 8'd0));
      chk(4,  "clean_prst_end", w(4'b0100, 2'd0, 8'd0));
      chk(19, "clean_pre_rdy",  w(4'b0100, 2'd0, 8'd0));
      chk(20, "clean_ready",    w(4'b0010, 2'd0, 8'd0));
      wait_edge(9);
      locked_in = 1'b1;
      wait_edge(22);

      // No lock: three attempts of 36 cycles, then FAULT and relock_req.
      do_reset(1'b0);
      chk(3,   "nolock_p1",      w(4'b1100, 2'd0, 8'd0));
      chk(4,   "nolock_w1",      w(4'b0100, 2'd0, 8'd0));
      chk(35,  "nolock_w1_end",  w(4'b0100, 2'd0, 8'd0));
      chk(36,  "nolock_p2",      w(4'b1100, 2'd1, 8'd0));
      chk(40,  "nolock_w2",      w(4'b0100, 2'd1, 8'd0));
      chk(72,  "nolock_p3",      w(4'b1100, 2'd2, 8'd0));
      chk(107, "nolock_pre_flt", w(4'b0100, 2'd2, 8'd0));
      chk(108, "nolock_fault",   w(4'b1101, 2'd2, 8'd0));
      chk(112, "nolock_hold",    w(4'b1101, 2'd2, 8'd0));
      chk(113, "nolock_relock",  w(4'b1100, 2'd0, 8'd0));
      wait_edge(112);
      relock_req = 1'b1;
      wait_edge(113);
      relock_req = 1'b0;
      wait_edge(114);

      // Glitch during STABLE after one timeout: retry stays 1, ready delayed.
      do_reset(1'b0);
      chk(36, "glitch_retry1",  w(4'b1100, 2'd1, 8'd0));
      chk(52, "glitch_stable",  w(4'b0100, 2'd1, 8'd0));
      chk(53, "glitch_wait",    w(4'b0100, 2'd1, 8'd0));
      chk(55, "glitch_no_run",  w(4'b0100, 2'd1, 8'd0));
      chk(61, "glitch_pre_rdy", w(4'b0100, 2'd1, 8'd0));
      chk(62, "glitch_ready",   w(4'b0010, 2'd1, 8'd0));
      wait_edge(44);
      locked_in = 1'b1;
      wait_edge(50);
      locked_in = 1'b0;
      wait_edge(51);
      locked_in = 1'b1;
      wait_edge(63);

      // Lock loss in RUN, then reset mid-WAIT_LOCK with relock_req held.
      do_reset(1'b0);
      chk(20, "loss_run",      w(4'b0010, 2'd0, 8'd0));
      chk(26, "loss_still_up", w(4'b0010, 2'd0, 8'd0));
`ifdef PLL_SEQ_AUTO_RELOCK_EN
      chk(27, "loss_down",     w(4'b1100, 2'd0, 8'd1));
      chk(30, "loss_prst",     w(4'b1100, 2'd0, 8'd1));
      chk(31, "loss_wait",     w(4'b0100, 2'd0, 8'd1));
      chk(39, "loss_pre_rdy",  w(4'b0100, 2'd0, 8'd1));
      chk(40, "loss_relocked", w(4'b0010, 2'd0, 8'd1));
      chk(45, "loss_relock",   w(4'b1100, 2'd0, 8'd1));
`else
      chk(27, "loss_down",     w(4'b0100, 2'd0, 8'd1));
      chk(40, "loss_lost",     w(4'b0100, 2'd0, 8'd1));
      chk(41, "loss_relock",   w(4'b1100, 2'd0, 8'd1));
      chk(44, "loss_prst",     w(4'b1100, 2'd0, 8'd1));
      chk(45, "loss_wait",     w(4'b0100, 2'd0, 8'd1));
`endif
      chk(51, "midrst_wait",   w(4'b0100, 2'd0, 8'd1));
      chk(52, "midrst_vals",   w(4'b1100, 2'd0, 8'd0));
      chk(53, "midrst_after",  w(4'b1100, 2'd0, 8'd0));
      wait_edge(9);
      locked_in = 1'b1;
      wait_edge(24);
      locked_in = 1'b0;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
      wait_edge(27);
      locked_in = 1'b1;
      wait_edge(44);
      relock_req = 1'b1;
      locked_in  = 1'b0;
      wait_edge(45);
      relock_req = 1'b0;
`else
      wait_edge(40);
      relock_req = 1'b1;
      wait_edge(41);
      relock_req = 1'b0;
`endif
      wait_edge(51);
      rst        = 1'b1;
      relock_req = 1'b1;
      wait_edge(52);
      rst        = 1'b0;
      relock_req = 1'b0;
      wait_edge(54);

      // Saturation: 300 lock-loss events in RUN.
      do_reset(1'b1);
      t0 = 0;
      for (int i = 0; i < 300; i++) begin
         chk(t0 + 13, "sat_run", w(4'b0010, 2'd0, sat8(i)));
`ifdef PLL_SEQ_AUTO_RELOCK_EN
         chk(t0 + 16, "sat_loss", w(4'b1100, 2'd0, sat8(i + 1)));
`else
         chk(t0 + 16, "sat_loss", w(4'b0100, 2'd0, sat8(i + 1)));
`endif
         wait_edge(t0 + 13);
         locked_in = 1'b0;
         wait_edge(t0 + 16);
         locked_in = 1'b1;
`ifdef PLL_SEQ_AUTO_RELOCK_EN
         t0 = t0 + 16;
`else
         relock_req = 1'b1;
         wait_edge(t0 + 17);
         relock_req = 1'b0;
         t0 = t0 + 17;
`endif
      end
      wait_edge(t0 + 2);

      repeat (3) @(negedge refclk);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         failures++;
         $display("FAIL %s never checked (due edge %0d, now edge %0d)", e.name, e.cyc, edge_n);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
